// File: rtl/downlink_serializer.sv
// Downlink framing serializer: buffers one byte behind a valid/ready handshake and shifts it
// out as an NRZ frame (start, data MSB-first, optional even parity, stop). Bit timing comes
// from rising edges of the sampled 1 MHz divider output; everything runs on the system clock.
module downlink_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PARITY_EN  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bit_clk,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    // Bit counter must be at least one bit wide even for a 1-bit payload.
    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic                  bit_clk_q;
    logic                  tick;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  parity_q, parity_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  frame_done_q, frame_done_d;
    logic                  xfer;

    // One-cycle bit tick on each sampled rising edge of the divider output.
    assign tick = bit_clk & ~bit_clk_q;

    // Holding register moves into the shift register only at a frame boundary tick.
    assign xfer = tick & hold_full_q & ((state_q == StIdle) | (state_q == StStop));

    assign shift_next = shift_q << 1;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the FSM only advances on a bit tick.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (hold_full_q) state_d = StStart;
                end
                StStart: state_d = StData;
                StData: begin
                    if (bit_cnt_q == '0) state_d = (PARITY_EN != 0) ? StParity : StStop;
                end
                StParity: state_d = StStop;
                StStop: state_d = hold_full_q ? StStart : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath and output next-state: line value, shifter, parity, counter, buffer.
    always_comb begin
        tx_d         = tx_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        frame_done_d = 1'b0;
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;

        if (tick) begin
            case (state_q)
                StIdle: begin
                    tx_d = 1'b1;
                end
                StStart: begin
                    tx_d      = shift_q[DATA_WIDTH-1];
                    bit_cnt_d = LastCnt;
                end
                StData: begin
                    if (bit_cnt_q != '0) begin
                        shift_d   = shift_next;
                        tx_d      = shift_next[DATA_WIDTH-1];
                        bit_cnt_d = bit_cnt_q - CntW'(1);
                    end else begin
                        tx_d = (PARITY_EN != 0) ? parity_q : 1'b1;
                    end
                end
                StParity: begin
                    tx_d = 1'b1;
                end
                StStop: begin
                    frame_done_d = 1'b1;
                    tx_d         = 1'b1;
                end
                default: begin
                    tx_d = 1'b1;
                end
            endcase
        end

        // Frame boundary with a buffered byte: start the next frame with no idle bit.
        if (xfer) begin
            shift_d     = hold_data_q;
            parity_d    = ^hold_data_q;
            tx_d        = 1'b0;
            hold_full_d = 1'b0;
        end

        // Accept never collides with xfer since data_ready is low while the buffer is full.
        if (data_valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_data_d = data_in;
        end
    end

    // Datapath registers; reset abandons any frame and drops the buffered byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_clk_q    <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_data_q  <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bit_cnt_q    <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            bit_clk_q    <= bit_clk;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Outputs come straight from registers or a state decode.
    always_comb begin
        data_ready = ~hold_full_q;
        tx_out     = tx_q;
        busy       = (state_q != StIdle);
        frame_done = frame_done_q;
    end

endmodule
